// File: rtl/hes_stream_decipher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hes_pkg
// Brief    : Shared definitions for the HES stream cipher pair: byte width,
//            decipher FSM state type and the AES S-box keystream table.
// Revision : 1.0 - initial release
// ============================================================================
package hes_pkg;

   localparam int BYTE_W = 8;

   // Message-tracking state of the receive side
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      RESYNC = 2'd2
   } state_t;

   // AES forward S-box; the transmitter derives its keystream from the same table
   localparam logic [BYTE_W-1:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage
`default_nettype wire

// File: rtl/hes_ks_sbox.sv
`default_nettype none
// ============================================================================
// Module   : hes_ks_sbox
// Brief    : Combinational 8-bit AES S-box lookup producing one keystream byte.
// Revision : 1.0 - initial release
// ============================================================================
module hes_ks_sbox
   import hes_pkg::*;
(
   input  logic [BYTE_W-1:0] idx,
   output logic [BYTE_W-1:0] sub
);

   // Pure table lookup, no state
   always_comb begin
      sub = SBOX[idx];
   end

endmodule
`default_nettype wire

// File: rtl/hes_stream_decipher.sv
`default_nettype none
// ============================================================================
// Module   : hes_stream_decipher
// Brief    : Receive-side counter-mode decipher. Checks per-message counter
//            continuity, regenerates the keystream and emits plaintext through
//            a two-stage valid/ready pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module hes_stream_decipher
   import hes_pkg::*;
#(
   parameter int OUT_CNT_EN = 1
)
(
   input  logic              clk,
   input  logic              rst_n,          // asynchronous, asserted high
   input  logic [BYTE_W-1:0] key,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              new_message,
   input  logic [BYTE_W-1:0] cipher_byte,
   input  logic [BYTE_W-1:0] counter_block,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] plain_byte,
   output logic [BYTE_W-1:0] out_counter,
   output logic              sync_err,
   output logic [BYTE_W-1:0] err_count
);

   state_t            state;
   state_t            state_nxt;
   logic [BYTE_W-1:0] key_l;
   logic [BYTE_W-1:0] exp_ctr;
   logic [BYTE_W-1:0] exp_ctr_nxt;

   logic              accept;
   logic              take;          // accepted byte enters the pipeline
   logic              mismatch;      // accepted byte breaks counter continuity
   logic              load_key;      // accepted byte opens a new message
   logic [BYTE_W-1:0] kx_in;

   logic              s1_valid;
   logic [BYTE_W-1:0] s1_cipher;
   logic [BYTE_W-1:0] s1_kx;
   logic [BYTE_W-1:0] s1_ctr;

   logic              s2_valid;
   logic              s2_ready;
   logic [BYTE_W-1:0] s2_plain;
   logic [BYTE_W-1:0] s2_ctr;
   logic [BYTE_W-1:0] ks;

   // Pipeline handshake: a stage may load when the stage after it is empty or draining
   always_comb begin
      s2_ready = !s2_valid || out_ready;
      in_ready = !s1_valid || s2_ready;
      accept   = in_valid && in_ready;
   end

   // Next-state logic and per-byte accept/discard decision
   always_comb begin
      state_nxt   = state;
      exp_ctr_nxt = exp_ctr;
      take        = 1'b0;
      mismatch    = 1'b0;
      load_key    = 1'b0;
      if (accept) begin
         case (state)
            IDLE, RESYNC: begin
               if (new_message) begin
                  take        = 1'b1;
                  load_key    = 1'b1;
                  exp_ctr_nxt = counter_block + 8'd1;
                  state_nxt   = RUN;
               end
            end
            RUN: begin
               if (new_message) begin
                  take        = 1'b1;
                  load_key    = 1'b1;
                  exp_ctr_nxt = counter_block + 8'd1;
               end else if (counter_block == exp_ctr) begin
                  take        = 1'b1;
                  exp_ctr_nxt = exp_ctr + 8'd1;
               end else begin
                  mismatch    = 1'b1;
                  state_nxt   = RESYNC;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
      // The first byte of a message is keyed with the live key being latched
      kx_in = (load_key ? key : key_l) ^ counter_block;
   end

   // FSM, latched key, expected counter and error reporting update at acceptance
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state     <= IDLE;
         key_l     <= '0;
         exp_ctr   <= '0;
         sync_err  <= 1'b0;
         err_count <= '0;
      end else begin
         state    <= state_nxt;
         exp_ctr  <= exp_ctr_nxt;
         sync_err <= mismatch;
         if (load_key) begin
            key_l <= key;
         end
         if (mismatch && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

   // Stage 1: capture ciphertext, S-box index and counter of each kept byte
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         s1_valid  <= 1'b0;
         s1_cipher <= '0;
         s1_kx     <= '0;
         s1_ctr    <= '0;
      end else if (take) begin
         s1_valid  <= 1'b1;
         s1_cipher <= cipher_byte;
         s1_kx     <= kx_in;
         s1_ctr    <= counter_block;
      end else if (s2_ready) begin
         s1_valid  <= 1'b0;
      end
   end

   hes_ks_sbox u_ks_sbox (
      .idx (s1_kx),
      .sub (ks)
   );

   // Stage 2: keystream XOR result, held while the consumer stalls
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         s2_valid <= 1'b0;
         s2_plain <= '0;
         s2_ctr   <= '0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_plain <= s1_cipher ^ ks;
            s2_ctr   <= s1_ctr;
         end
      end
   end

   assign out_valid  = s2_valid;
   assign plain_byte = s2_plain;

   generate
      if (OUT_CNT_EN != 0) begin : g_out_cnt_on
         assign out_counter = s2_ctr;
      end else begin : g_out_cnt_off
         assign out_counter = '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hes_stream_decipher.sv
`default_nettype none
// ============================================================================
// Module   : tb_hes_stream_decipher
// Brief    : Self-checking bench for hes_stream_decipher with an independent
//            message-level reference model and directed plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hes_stream_decipher;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] key;
   logic       in_valid;
   logic       in_ready;
   logic       new_message;
   logic [7:0] cipher_byte;
   logic [7:0] counter_block;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] plain_byte;
   logic [7:0] out_counter;
   logic       sync_err;
   logic [7:0] err_count;

   hes_stream_decipher #(.OUT_CNT_EN(1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key           (key),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .new_message   (new_message),
      .cipher_byte   (cipher_byte),
      .counter_block (counter_block),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .plain_byte    (plain_byte),
      .out_counter   (out_counter),
      .sync_err      (sync_err),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // S-box rebuilt from its definition: GF(2^8) inverse followed by the affine map
   logic [7:0] sbox_m [256];

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a = a_in;
      logic [7:0] b = b_in;
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
         sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   // Reference model: whether the receiver is locked onto a message, its key and next counter
   typedef struct {
      logic [7:0] p;
      logic [7:0] c;
      int         t;
   } exp_t;

   exp_t       q[$];
   bit         locked;
   logic [7:0] m_key;
   logic [7:0] m_next;
   int         m_err;
   bit         sync_exp;
   bit         hold_v;
   logic [7:0] hold_p;
   logic [7:0] hold_c;
   int         cyc_n;
   bit         last_acc;
   int         sync_seen;
   int         ready_low;
   logic [7:0] log_p[$];
   logic [7:0] log_c[$];
   int         log_lat[$];

   task automatic model_reset();
      q.delete();
      locked   = 1'b0;
      m_key    = 8'h00;
      m_next   = 8'h00;
      m_err    = 0;
      sync_exp = 1'b0;
      hold_v   = 1'b0;
   endtask

   task automatic model_accept();
      exp_t e;
      if (new_message) begin
         m_key  = key;
         locked = 1'b1;
         m_next = counter_block + 8'd1;
         e.p = cipher_byte ^ sbox_m[key ^ counter_block];
         e.c = counter_block;
         e.t = cyc_n;
         q.push_back(e);
      end else if (locked) begin
         if (counter_block == m_next) begin
            e.p = cipher_byte ^ sbox_m[m_key ^ counter_block];
            e.c = counter_block;
            e.t = cyc_n;
            q.push_back(e);
            m_next = m_next + 8'd1;
         end else begin
            locked   = 1'b0;
            sync_exp = 1'b1;
            if (m_err < 255) m_err++;
         end
      end
   endtask

   // One clock: check registered outputs mid-cycle, then apply this cycle's transfers to the model
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      cyc_n++;
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("sync_err", sync_err, sync_exp);
      chk("err_count", err_count, m_err[7:0]);
      if (hold_v) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_plain", plain_byte, hold_p);
         chk("hold_ctr", out_counter, hold_c);
      end
      hold_v = out_valid && !out_ready;
      hold_p = plain_byte;
      hold_c = out_counter;
      if (sync_err) sync_seen++;
      if (!in_ready) ready_low++;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_out", out_valid && out_ready, 1'b0);
         end else begin
            e = q.pop_front();
            chk("plain_byte", plain_byte, e.p);
            chk("out_counter", out_counter, e.c);
            log_p.push_back(plain_byte);
            log_c.push_back(out_counter);
            log_lat.push_back(cyc_n - e.t);
         end
      end
      last_acc = in_valid && in_ready;
      sync_exp = 1'b0;
      if (last_acc) model_accept();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit nm, input logic [7:0] k, input logic [7:0] ctr, input logic [7:0] cph);
      int tries = 0;
      in_valid      = 1'b1;
      new_message   = nm;
      key           = k;
      counter_block = ctr;
      cipher_byte   = cph;
      cycle();
      while (!last_acc && tries < 20) begin
         tries++;
         cycle();
      end
      if (!last_acc) chk("send_timeout", last_acc, 1'b1);
   endtask

   task automatic idle(input int n);
      in_valid    = 1'b0;
      new_message = 1'b0;
      repeat (n) cycle();
   endtask

   initial begin
      int         b;
      int         s0;
      int         e0;
      int         sent;
      logic [7:0] tx_next;

      build_sbox();
      model_reset();
      cyc_n = 0; sync_seen = 0; ready_low = 0; last_acc = 1'b0;
      key = 8'h00; in_valid = 1'b0; new_message = 1'b0;
      cipher_byte = 8'h00; counter_block = 8'h00; out_ready = 1'b1;
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_plain", plain_byte, 8'h00);
      chk("rst_out_counter", out_counter, 8'h00);
      chk("rst_sync_err", sync_err, 1'b0);
      chk("rst_err_count", err_count, 8'h00);
      rst_n = 1'b0;
      idle(2);

      // Basic decrypt with key 00
      b = log_p.size();
      send(1'b1, 8'h00, 8'h00, 8'h63);
      send(1'b0, 8'h00, 8'h01, 8'h7C);
      send(1'b0, 8'h00, 8'h02, 8'h77);
      idle(4);
      chk("basic_count", log_p.size() - b, 3);
      if (log_p.size() >= b + 3) begin
         for (int k = 0; k < 3; k++) begin
            chk("basic_plain", log_p[b + k], 8'h00);
            chk("basic_ctr", log_c[b + k], k);
         end
         chk("basic_latency", log_lat[b], 2);
      end

      // Key is latched at message start, not followed live
      b = log_p.size();
      send(1'b1, 8'h01, 8'h00, 8'h7C);
      send(1'b0, 8'h55, 8'h01, 8'h63);
      idle(4);
      chk("keylatch_count", log_p.size() - b, 2);
      if (log_p.size() >= b + 2) begin
         chk("keylatch_p0", log_p[b], 8'h00);
         chk("keylatch_p1", log_p[b + 1], 8'h00);
      end

      // Counter wrap FF -> 00 without error
      b = log_p.size(); s0 = sync_seen;
      send(1'b1, 8'h00, 8'hFE, 8'h5A);
      send(1'b0, 8'h00, 8'hFF, 8'h16);
      send(1'b0, 8'h00, 8'h00, 8'hA5);
      idle(4);
      chk("wrap_count", log_p.size() - b, 3);
      chk("wrap_no_sync", sync_seen - s0, 0);
      if (log_p.size() >= b + 3) begin
         chk("wrap_ff_plain", log_p[b + 1], 8'h00);
         chk("wrap_ctr_00", log_c[b + 2], 8'h00);
      end

      // Desync: 00,01,03 then 04,05 dropped until a new message at 10
      b = log_p.size(); s0 = sync_seen; e0 = err_count;
      send(1'b1, 8'h00, 8'h00, 8'h11);
      send(1'b0, 8'h00, 8'h01, 8'h22);
      send(1'b0, 8'h00, 8'h03, 8'h33);
      send(1'b0, 8'h00, 8'h04, 8'h44);
      send(1'b0, 8'h00, 8'h05, 8'h55);
      send(1'b1, 8'h00, 8'h10, 8'h66);
      idle(4);
      chk("desync_count", log_p.size() - b, 3);
      chk("desync_pulses", sync_seen - s0, 1);
      chk("desync_errcnt", err_count, e0 + 1);
      if (log_c.size() >= b + 3) chk("desync_resume_ctr", log_c[b + 2], 8'h10);

      // Backpressure: consumer stalls 5 cycles while the producer keeps pushing
      b = log_p.size(); s0 = ready_low; sent = 0;
      for (int i = 0; i < 40 && sent < 8; i++) begin
         in_valid      = 1'b1;
         new_message   = (sent == 0);
         key           = 8'h3C;
         counter_block = 8'h20 + sent[7:0];
         cipher_byte   = $urandom;
         out_ready     = !(i >= 2 && i < 7);
         cycle();
         if (last_acc) sent++;
      end
      out_ready = 1'b1;
      idle(4);
      chk("bp_ready_fell", ready_low > s0, 1'b1);
      chk("bp_count", log_c.size() - b, 8);
      if (log_c.size() >= b + 8)
         for (int k = 0; k < 8; k++) chk("bp_order", log_c[b + k], 8'h20 + k);

      // Reset in the middle of a stalled message
      send(1'b1, 8'h00, 8'h40, 8'h01);
      send(1'b0, 8'h00, 8'h41, 8'h02);
      in_valid = 1'b0;
      out_ready = 1'b0;
      cycle();
      rst_n = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_err_count", err_count, 8'h00);
      chk("midrst_in_ready", in_ready, 1'b1);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      out_ready = 1'b1;
      b = log_p.size();
      send(1'b0, 8'h00, 8'h42, 8'h03);
      idle(4);
      chk("midrst_discard", log_p.size() - b, 0);

      // Randomized traffic against the model
      tx_next = 8'h00;
      for (int i = 0; i < 1500; i++) begin
         in_valid      = ($urandom_range(3) != 0);
         out_ready     = ($urandom_range(3) != 0);
         new_message   = ($urandom_range(19) == 0);
         key           = $urandom;
         cipher_byte   = $urandom;
         counter_block = ($urandom_range(15) == 0) ? 8'($urandom) : tx_next;
         cycle();
         if (last_acc) tx_next = counter_block + 8'd1;
      end
      out_ready = 1'b1;
      idle(4);

      // Error counter saturates at FF
      for (int i = 0; i < 260; i++) begin
         send(1'b1, 8'h00, 8'h00, 8'h00);
         send(1'b0, 8'h00, 8'h05, 8'h00);
      end
      idle(4);
      chk("err_saturate", err_count, 8'hFF);
      chk("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hes_stream_decipher.md
# hes_stream_decipher

Receive-side counterpart of the AES stream cipher: consumes ciphertext bytes tagged with their counter block, regenerates the same keystream and emits plaintext bytes. It sits between the link/receive path and the consumer. It enforces counter continuity per message and reports desynchronisation. Flow control is valid/ready on both sides.

## Interface
- OUT_CNT_EN, default 1, 1 = drive out_counter with the byte's counter; 0 = tie out_counter to 8'h00.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high (asserted when rst_n = 1).
- key  in  8  cipher key; sampled only on an accepted new_message byte.
- in_valid  in  1  input byte present.
- in_ready  out  1  block can accept a byte this cycle.
- new_message  in  1  qualifies the accepted byte as the first byte of a message.
- cipher_byte  in  8  ciphertext byte.
- counter_block  in  8  counter value the transmitter used for this byte.
- out_valid  out  1  plaintext byte present.
- out_ready  in  1  consumer accepts the output byte.
- plain_byte  out  8  decrypted byte.
- out_counter  out  8  counter of the output byte.
- sync_err  out  1  one-cycle pulse on a counter mismatch.
- err_count  out  8  mismatch count, saturating at 8'hFF.

## Operation
- Keystream byte: ks = SBOX[key_l ^ ctr], using the AES S-box. The transmitter uses the same function. plain_byte = cipher_byte ^ ks.
- Transfer rule: an input is accepted when in_valid && in_ready. An output is taken when out_valid && out_ready.
- FSM states are IDLE, RUN and RESYNC. Reset state is IDLE.
- IDLE:
  - Accepted bytes without new_message are discarded silently.
  - An accepted byte with new_message: latch key_l = key and exp_ctr = counter_block + 1. Decrypt the byte with counter_block and go to RUN.
- RUN:
  - Accepted byte with new_message: restart exactly as from IDLE. The key is re-latched and no error is raised.
  - Accepted byte with counter_block == exp_ctr: decrypt it and increment exp_ctr mod 256 (FF wraps to 00, no error).
  - Accepted byte with counter_block != exp_ctr: discard it, pulse sync_err, increment err_count (saturating) and go to RESYNC.
- RESYNC: discard all accepted bytes until one arrives with new_message, then behave as in IDLE. No further sync_err pulses are raised while in RESYNC.
- new_message is ignored unless in_valid && in_ready.
- Discarded bytes never reach the output.

## Timing
- Reset values: in_ready = 1, out_valid = 0, plain_byte = 8'h00, out_counter = 8'h00, sync_err = 0, err_count = 0, FSM = IDLE, key_l = 0, exp_ctr = 0.
- Pipeline has two registered stages:
  - S1 registers cipher_byte, key_l ^ ctr and ctr.
  - S2 registers the S-box XOR result. S2 drives the outputs.
- Latency: an accepted byte at edge N appears on out_valid at edge N+2 when out_ready is held high.
- Throughput is 1 byte/cycle.
- Stall: in_ready = !s1_valid || !s2_valid || out_ready. Each stage advances when the stage after it is empty or is being drained.
- Outputs are held stable while out_valid && !out_ready.
- The FSM, exp_ctr and sync_err update at the acceptance edge, not at the output edge.
- Discarded bytes consume no pipeline slot.
- Asynchronous reset mid-message flushes both stages. Any pending out_valid drops immediately.

## Structure
- Shared package hes_pkg holds:
  - SBOX[256] constant, shared with the cipher.
  - state_t enum {IDLE, RUN, RESYNC}.
  - BYTE_W = 8.
- Sub-module hes_ks_sbox: combinational 8-bit S-box lookup, instantiated once in S2.

## Test plan
- Basic decrypt: key=00; bytes {63,7C,77}, ctr {00,01,02}, new_message on the first byte -> plain {00,00,00}, out_counter {00,01,02}, first out_valid 2 cycles after the first acceptance.
- Key latch: key=01, new_message, ctr 00, cipher 7C -> plain 00. Key then changes to 55 mid-message; next byte ctr 01, cipher SBOX[01^01]=63 -> plain 00. This confirms the key is latched, not live.
- Wrap: a message starting with ctr FE (key 00) -> FF, then 00 accepted with no sync_err. The byte at ctr FF with cipher 16 -> plain 00.
- Desync: ctr sequence 00, 01, 03 -> one sync_err pulse, err_count=1, byte 03 not output. Following bytes 04 and 05 without new_message are dropped. A new_message byte at ctr 10 resumes output.
- Backpressure: out_ready=0 for 5 cycles during a stream -> in_ready falls once both stages fill. No byte is lost or duplicated and the output holds stable. Output resumes in order on release.
- Reset mid-stream: assert rst_n during RUN with out_valid=1 -> out_valid=0 immediately and err_count=0. A byte without new_message is then discarded (IDLE).
